// File: rtl/eval_pkg.sv
// Shared definitions for the eval operand feeder and its FIFO.
package eval_pkg;

    localparam int DATA_W = 8;

    // Feeder activity state; anything other than IDLE keeps the eval stage clocked.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_e;

    // One operand pair as stored in the FIFO: {kernel, b, a}.
    typedef struct packed {
        logic              kernel;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] a;
    } pair_t;

endpackage

// File: rtl/feeder_fifo.sv
// Small synchronous FIFO; full/empty come from an extra wrap bit on each pointer.
module feeder_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    // Pointer update; clear empties the FIFO regardless of push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/eval_operand_feeder.sv
// Upstream feeder for eval_module: buffers operand pairs, issues one per cycle,
// tracks the 1-cycle result latency and gates the eval stage clock when idle.
//
// Handshake: a pair is transferred on a rising edge where in_valid && in_ready;
// in_ready depends only on internal state (never on in_valid), and the upstream
// must hold in_valid and the operands stable until that edge.
module eval_operand_feeder
    import eval_pkg::*;
#(
    parameter int DATA_W = eval_pkg::DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_kernel,
    input  logic              out_hold,
    output logic [DATA_W-1:0] data_in1,
    output logic [DATA_W-1:0] data_in2,
    output logic              kernel_enable,
    output logic              issue_valid,
    output logic              result_valid,
    output logic              gate_en,
    output logic [CNT_W-1:0]  issue_count,
    output state_e            fsm_state
);

    localparam int PAIR_W = 2 * DATA_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              ready_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PAIR_W-1:0] fifo_rdata;
    logic              push;
    logic              pop;
    logic              fire;
    logic              kernel_q;
    state_e            state_q;
    state_e            state_d;

    // in_ready stays low during reset and for the first edge after release.
    assign in_ready = ready_q && !fifo_full;
    assign push     = in_valid && in_ready && !flush;
    assign pop      = !flush && !out_hold && !fifo_empty;
    // The eval stage samples the issued pair on every edge where fire is high.
    assign fire     = issue_valid && !out_hold;

    assign kernel_enable = kernel_q && issue_valid;
    assign gate_en       = (state_q != IDLE);
    assign fsm_state     = state_q;

    feeder_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({in_kernel, in_b, in_a}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Ready qualifier: comes up one edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= 1'b1;
    end

    // Issue register: loads the FIFO head when not stalled; operands hold when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_in1    <= '0;
            data_in2    <= '0;
            kernel_q    <= 1'b0;
            issue_valid <= 1'b0;
        end else if (flush) begin
            kernel_q    <= 1'b0;
            issue_valid <= 1'b0;
        end else if (!out_hold) begin
            if (!fifo_empty) begin
                data_in1    <= fifo_rdata[DATA_W-1:0];
                data_in2    <= fifo_rdata[2*DATA_W-1:DATA_W];
                kernel_q    <= fifo_rdata[PAIR_W-1];
                issue_valid <= 1'b1;
            end else begin
                kernel_q    <= 1'b0;
                issue_valid <= 1'b0;
            end
        end
    end

    // Result-valid pipe and consumed-pair counter, both keyed off fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_valid <= 1'b0;
            issue_count  <= '0;
        end else if (flush) begin
            result_valid <= 1'b0;
            issue_count  <= '0;
        end else begin
            result_valid <= fire;
            if (fire) issue_count <= issue_count + CNT_ONE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: BUSY drops to IDLE during the cycle that carries the last
    // result_valid, so the eval clock stops right after the result is seen.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (push) state_d = BUSY;
            BUSY: begin
                if (out_hold && issue_valid)                   state_d = HOLD;
                else if (fifo_empty && !issue_valid && !push)  state_d = IDLE;
            end
            HOLD: if (!out_hold) state_d = BUSY;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

endmodule
